// File: rtl/ring_inj_scheduler.sv
// Local-side controller for a bufferless ring router: round-robin injection
// arbiter with a single held flit, ejection sink occupancy tracking and error flags.
module ring_inj_scheduler #(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned FLIT_W       = 144,
  parameter int unsigned VALID_BIT    = 11,
  parameter int unsigned EJ_DEPTH     = 4,
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NREQ*FLIT_W-1:0]           req_flit,
  input  logic [NREQ-1:0]                  req_valid,
  output logic [NREQ-1:0]                  req_ready,
  output logic [FLIT_W-1:0]                inj,
  input  logic                             accept,
  input  logic                             push,
  input  logic [FLIT_W-1:0]                eject,
  input  logic                             ej_pop,
  output logic                             bfull,
  output logic [$clog2(EJ_DEPTH+1)-1:0]    ej_count,
  output logic                             starve,
  output logic                             err_drop,
  output logic                             err_ovf
);

  localparam int unsigned PW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(EJ_DEPTH+1);
  localparam int unsigned SW = $clog2(STARVE_LIMIT+1);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t              state;
  logic [PW-1:0]       rr_ptr;
  logic [PW-1:0]       grant_idx;
  logic                grant_any;
  logic                do_grant;
  logic [FLIT_W-1:0]   grant_flit;
  logic [SW-1:0]       starve_cnt;
  logic [SW-1:0]       starve_nxt;
  logic [CW-1:0]       ej_nxt;
  logic                ovf_set;
  logic                push_ok;
  logic                eject_unused;

  // Only the valid bit of the ejected flit matters here.
  assign eject_unused = ^eject;

  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(rr_ptr) + k) % NREQ;
      if (!grant_any && req_valid[PW'(idx)]) begin
        grant_any = 1'b1;
        grant_idx = PW'(idx);
      end
    end
  end

  // A new grant is possible from IDLE, or in OFFER on the accept cycle (zero bubble).
  assign do_grant   = grant_any && (state == IDLE || accept) && !rst;
  assign req_ready  = do_grant ? (NREQ'(1) << grant_idx) : '0;
  assign grant_flit = req_flit[grant_idx*FLIT_W +: FLIT_W];

  always_comb begin
    starve_nxt = starve_cnt;
    if (state == OFFER) begin
      if (accept)
        starve_nxt = '0;
      else if (starve_cnt != SW'(STARVE_LIMIT))
        starve_nxt = starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      inj        <= '0;
      err_drop   <= 1'b0;
      starve_cnt <= '0;
      starve     <= 1'b0;
    end else begin
      err_drop   <= 1'b0;
      starve_cnt <= starve_nxt;
      starve     <= (starve_nxt == SW'(STARVE_LIMIT));
      if (do_grant) begin
        rr_ptr <= PW'((32'(grant_idx) + 32'd1) % NREQ);
        if (grant_flit[VALID_BIT]) begin
          state <= OFFER;
          inj   <= grant_flit;
        end else begin
          state    <= IDLE;
          inj      <= '0;
          err_drop <= 1'b1;
        end
      end else if (state == OFFER && accept) begin
        state <= IDLE;
        inj   <= '0;
      end
    end
  end

  always_comb begin
    push_ok = push && eject[VALID_BIT];
    ej_nxt  = ej_count;
    ovf_set = push && !eject[VALID_BIT];
    if (push_ok && !ej_pop) begin
      if (ej_count == CW'(EJ_DEPTH))
        ovf_set = 1'b1;
      else
        ej_nxt = ej_count + 1'b1;
    end else if (ej_pop && !push_ok) begin
      if (ej_count == '0)
        ovf_set = 1'b1;
      else
        ej_nxt = ej_count - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ej_count <= '0;
      bfull    <= 1'b0;
      err_ovf  <= 1'b0;
    end else begin
      ej_count <= ej_nxt;
      bfull    <= (ej_nxt == CW'(EJ_DEPTH));
      if (ovf_set)
        err_ovf <= 1'b1;
    end
  end

endmodule

// File: doc/ring_inj_scheduler.md
Name: ring_inj_scheduler

Overview:
- Per-node controller for the bufferless ring router's local side.
- Arbitrates NREQ local requesters (MSHR/reply queues) round-robin onto the router's single 144-bit injection port, holding each granted flit on inj until the router pulses accept.
- Tracks ejection-sink occupancy from the router's push strobe and drives the router's bfull input.
- Flags injection starvation and protocol errors.

Parameters:
- NREQ, 4, number of local requesters (2..8).
- FLIT_W, 144, flit width; equals `control_w.
- VALID_BIT, 11, index of the flit valid bit.
- EJ_DEPTH, 4, ejection sink capacity in flits.
- STARVE_LIMIT, 16, consecutive unaccepted offer cycles before starve asserts.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_flit  in  NREQ*FLIT_W  requester flits; requester i occupies bits [i*FLIT_W +: FLIT_W].
- req_valid  in  NREQ  requester i has a flit.
- req_ready  out  NREQ  one-hot pulse; flit i captured this cycle.
- inj  out  FLIT_W  to router inj; all zeros when nothing is held.
- accept  in  1  from router; held flit taken this cycle.
- push  in  1  from router; one flit delivered on eject this cycle.
- eject  in  FLIT_W  from router; used for the valid-bit check only.
- ej_pop  in  1  sink consumer frees one slot.
- bfull  out  1  to router; ejection sink full.
- ej_count  out  clog2(EJ_DEPTH+1)  current sink occupancy.
- starve  out  1  injection starved.
- err_drop  out  1  pulse; a granted flit had its valid bit clear and was discarded.
- err_ovf  out  1  sticky; push while full, or pop while empty.

Behaviour:
- Reset (async, immediate) values:
  - inj=0, req_ready=0, bfull=0, ej_count=0, starve=0, err_drop=0, err_ovf=0.
  - State IDLE; rr_ptr=0; starve_cnt=0.
  - Reset mid-offer discards the held flit; the requester is not re-notified.
- FSM, IDLE state:
  - If any req_valid: grant g = first set index searching rr_ptr, rr_ptr+1, ... modulo NREQ.
  - Same cycle: assert req_ready[g] (combinational, one-hot) and capture req_flit[g] at the clock edge.
  - rr_ptr <= (g+1) mod NREQ.
  - If the captured flit has VALID_BIT=1, go to OFFER. Otherwise pulse err_drop next cycle and stay in IDLE.
  - Grant-to-inj latency: 1 cycle.
- FSM, OFFER state:
  - inj = held flit, constant until accept.
  - If accept is low: starve_cnt++ (saturating at STARVE_LIMIT).
  - If accept is high: clear starve_cnt. If a req_valid exists, perform the IDLE grant in the same cycle, so back-to-back flits see zero bubble. Otherwise go to IDLE and drive inj=0 next cycle.
- req_ready is never asserted in OFFER unless accept=1.
- accept while in IDLE is ignored.
- starve = (starve_cnt == STARVE_LIMIT). It clears the cycle after accept.
- Ejection sink counter:
  - push only: +1. ej_pop only: -1. Both: unchanged.
  - push when ej_count==EJ_DEPTH and no pop: count held, err_ovf set.
  - Pop at 0 and no push: count held, err_ovf set.
  - push with eject[VALID_BIT]=0 does not count and sets err_ovf.
- bfull = (ej_count == EJ_DEPTH), registered from the counter. The router sees full one cycle after the filling push.
- err_ovf clears only on rst.

Test Plan:
- Reset, then req_valid=4'b0001 with flit 144'h011111111111111111111111111111111854 (bit 11 set) -> req_ready=0001 in that cycle; next cycle inj equals the flit; accept pulse -> inj=0 the following cycle; rr_ptr=1.
- All four req_valid held high, accept pulsed every cycle -> grants in order 0,1,2,3,0; zero idle cycles on inj; req_ready strictly one-hot.
- Flit with bit 11 clear from requester 2 -> req_ready[2] pulses; err_drop=1 for one cycle; inj stays 0; FSM in IDLE.
- Hold a flit with accept=0 for 16 cycles -> starve rises on the 16th unaccepted cycle; single accept -> starve=0 next cycle and inj changes.
- With EJ_DEPTH=4: four push pulses with valid eject flits -> ej_count=4 and bfull=1. Then push and ej_pop together -> count stays 4, err_ovf=0. Then push alone -> err_ovf=1, count 4.
- Assert rst mid-OFFER -> inj=0, req_ready=0, bfull=0 immediately without a clock edge; after release, the first grant starts from requester 0.
